// File: rtl/player_hp_bitmap.sv
// player_hp_bitmap
// Heart-row renderer and hit-point keeper for the player HP bracket.
// It takes the bracket's pixel offsets and returns one registered pixel,
// so its outputs lag its inputs by exactly one clock.
// It owns hp, an invulnerability window that blinks, and a dead flag
// that stays set until reset.
// Optional build macro HP_EMPTY_OUTLINE_EN: lost hearts are drawn in
// EMPTY_COLOR instead of being left transparent.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_ALIVE   | normal play; a hit costs one heart
// ST_INVULN  | immune after a hit; counts frames down and blinks the hearts
// ST_DEAD    | hp is 0; hit and heal are ignored until reset
module player_hp_bitmap #(
    parameter int         MAX_HP        = 3,
    parameter int         INVULN_FRAMES = 60,
    parameter logic [7:0] HEART_COLOR   = 8'hE0,
    parameter logic [7:0] EMPTY_COLOR   = 8'h92
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic [10:0] offsetX,
    input  logic [10:0] offsetY,
    input  logic        InsideRectangle,
    input  logic        hit,
    input  logic        heal,
    output logic        drawingRequest,
    output logic [7:0]  RGBout,
    output logic [2:0]  hp,
    output logic        dead
);

    localparam logic [1:0] ST_ALIVE  = 2'd0;
    localparam logic [1:0] ST_INVULN = 2'd1;
    localparam logic [1:0] ST_DEAD   = 2'd2;

    localparam logic [2:0] HP_MAX      = 3'(MAX_HP);
    localparam logic [5:0] HEART_COUNT = 6'(MAX_HP);
    localparam logic [7:0] INVULN_LOAD = 8'(INVULN_FRAMES);
    localparam logic [7:0] TRANSPARENT = 8'hFF;

    logic [1:0] state;
    logic [7:0] invuln_cnt;
    logic [7:0] frame_cnt;

    logic [5:0] heart_idx;
    logic [2:0] tile_x;
    logic [2:0] tile_y;
    logic [7:0] mask_row;
    logic       mask_bit;
    logic       in_heart;
    logic       heart_full;
    logic       blink_off;
    logic       px_opaque;
    logic       px_empty;

    // Offset bits below the x4 scaling carry no information for the mask.
    logic unused_offset_bits;
    assign unused_offset_bits = &{1'b0, offsetX[1:0], offsetY[1:0]};

    // Hit-point state machine. A simultaneous heal is dropped whenever hit
    // is asserted, even if the hit itself is swallowed by invulnerability.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_ALIVE;
            hp         <= HP_MAX;
            dead       <= 1'b0;
            invuln_cnt <= 8'd0;
        end else begin
            case (state)
                ST_ALIVE: begin
                    if (hit) begin
                        if (hp > 3'd1) begin
                            hp         <= hp - 3'd1;
                            invuln_cnt <= INVULN_LOAD;
                            state      <= ST_INVULN;
                        end else begin
                            hp    <= 3'd0;
                            dead  <= 1'b1;
                            state <= ST_DEAD;
                        end
                    end else if (heal && (hp < HP_MAX)) begin
                        hp <= hp + 3'd1;
                    end
                end
                ST_INVULN: begin
                    if (!hit && heal && (hp < HP_MAX)) begin
                        hp <= hp + 3'd1;
                    end
                    if (startOfFrame) begin
                        // A zero count cannot occur here; <= 1 keeps it from wrapping.
                        if (invuln_cnt <= 8'd1) begin
                            invuln_cnt <= 8'd0;
                            state      <= ST_ALIVE;
                        end else begin
                            invuln_cnt <= invuln_cnt - 8'd1;
                        end
                    end
                end
                ST_DEAD: begin
                    state <= ST_DEAD;
                end
                default: begin
                    state <= ST_ALIVE;
                end
            endcase
        end
    end

    // Free-running frame counter; its bit 3 sets the blink rate.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= 8'd0;
        end else if (startOfFrame) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign heart_idx = offsetX[10:5];
    assign tile_x    = offsetX[4:2];
    assign tile_y    = offsetY[4:2];

    // 8x8 heart mask ROM; bit 7 is the leftmost column.
    always_comb begin
        mask_row = 8'b00000000;
        case (tile_y)
            3'd0:    mask_row = 8'b01100110;
            3'd1:    mask_row = 8'b11111111;
            3'd2:    mask_row = 8'b11111111;
            3'd3:    mask_row = 8'b11111111;
            3'd4:    mask_row = 8'b01111110;
            3'd5:    mask_row = 8'b00111100;
            3'd6:    mask_row = 8'b00011000;
            default: mask_row = 8'b00000000;
        endcase
    end

    assign mask_bit   = mask_row[3'd7 - tile_x];
    assign in_heart   = InsideRectangle && (offsetY < 11'd32) &&
                        (heart_idx < HEART_COUNT) && mask_bit;
    assign heart_full = heart_idx < {3'b000, hp};
    assign blink_off  = (state == ST_INVULN) && frame_cnt[3];

    // Pixel decision. The blink only affects full hearts.
    always_comb begin
        px_opaque = 1'b0;
        px_empty  = 1'b0;
        if (in_heart) begin
            if (heart_full) begin
                px_opaque = !blink_off;
            end
`ifdef HP_EMPTY_OUTLINE_EN
            else begin
                px_opaque = 1'b1;
                px_empty  = 1'b1;
            end
`else
            else begin
                px_opaque = 1'b0;
                px_empty  = 1'b0;
            end
`endif
        end
    end

    // Output register stage for the video mux.
    always_ff @(posedge clk) begin
        if (reset) begin
            drawingRequest <= 1'b0;
            RGBout         <= TRANSPARENT;
        end else begin
            drawingRequest <= px_opaque;
            RGBout         <= px_opaque ? (px_empty ? EMPTY_COLOR : HEART_COLOR)
                                        : TRANSPARENT;
        end
    end

endmodule
